fsm_rr_scheduler: RTL and testbench



---
 rtl/fsm_rr_scheduler_pkg.sv | 16 +
 rtl/fsm_rr_scheduler_if.sv | 28 ++
 rtl/fsm_rr_scheduler_rr_picker.sv | 29 ++
 rtl/fsm_rr_scheduler.sv | 143 ++++++++++++++
 tb/tb_fsm_rr_scheduler.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fsm_rr_scheduler_pkg.sv
// Shared types for the round-robin fsm scheduler: job sequencing states and
// the encodings the shared fsm reports on its state bus.
package fsm_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT1 = 3'd2,
    S_RUN   = 3'd3,
    S_DRAIN = 3'd4
  } sched_state_e;

  localparam int unsigned FSM_ST_IDLE = 0;
  localparam int unsigned FSM_ST_BUSY = 1;

endpackage

// File: rtl/fsm_rr_scheduler_if.sv
// Requester/fsm-facing bundle of the scheduler. master = scheduler side,
// slave = requesters plus the shared fsm.
interface fsm_rr_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int STATE_W = 8,
  parameter int IDX_W   = $clog2(NUM_REQ)
) ();
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] req_done;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] ack;
  logic [IDX_W-1:0]   owner;
  logic               busy;
  logic               fsm_start;
  logic               fsm_done;
  logic [STATE_W-1:0] fsm_state;
  logic               err;

  modport master (
    input  req, req_done, fsm_state,
    output grant, ack, owner, busy, fsm_start, fsm_done, err
  );

  modport slave (
    output req, req_done, fsm_state,
    input  grant, ack, owner, busy, fsm_start, fsm_done, err
  );
endinterface

// File: rtl/fsm_rr_scheduler_rr_picker.sv
// Combinational round-robin select: first asserted request at or after the
// pointer, wrapping around.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic               o_valid,
  output logic [IDX_W-1:0]   o_index
);

  logic [IDX_W-1:0] w_idx;

  // Scan from the farthest offset down so the nearest hit is written last.
  always_comb begin
    o_valid = 1'b0;
    o_index = '0;
    w_idx   = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      w_idx = IDX_W'((int'(i_ptr) + off) % NUM_REQ);
      if (i_req[w_idx]) begin
        o_valid = 1'b1;
        o_index = w_idx;
      end
    end
  end

endmodule

// File: rtl/fsm_rr_scheduler.sv
// Round-robin scheduler time-sharing one fsm among NUM_REQ requesters.
// Define FSM_SCHED_TIMEOUT_EN to add the watchdog that aborts stuck jobs.
module fsm_rr_scheduler
  import fsm_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ),
  parameter int STATE_W = 8,
  parameter int TIMEOUT = 255
) (
  input logic               clock,
  input logic               reset,
  fsm_rr_scheduler_if.master bus
);

  localparam logic [2:0] ST_IDLE  = S_IDLE;
  localparam logic [2:0] ST_START = S_START;
  localparam logic [2:0] ST_WAIT1 = S_WAIT1;
  localparam logic [2:0] ST_RUN   = S_RUN;
  localparam logic [2:0] ST_DRAIN = S_DRAIN;

  if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT < 1) begin : g_cfg_err
    $error("fsm_rr_scheduler: unsupported NUM_REQ/TIMEOUT");
  end

  logic [2:0]         r_state;
  logic [IDX_W-1:0]   r_ptr;
  logic [NUM_REQ-1:0] r_grant;
  logic [NUM_REQ-1:0] r_ack;
  logic [IDX_W-1:0]   r_owner;
  logic               r_busy;
  logic               r_start;
  logic               r_done;

  logic               w_pick_vld;
  logic [IDX_W-1:0]   w_pick_idx;
  logic               w_st_idle;
  logic               w_st_busy;
  logic               w_own_done;
  logic [IDX_W-1:0]   w_next_ptr;
  logic               w_tmo;
  logic               w_release;

  rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_picker (
    .i_req   (bus.req),
    .i_ptr   (r_ptr),
    .o_valid (w_pick_vld),
    .o_index (w_pick_idx)
  );

  assign w_st_idle  = (bus.fsm_state == STATE_W'(FSM_ST_IDLE));
  assign w_st_busy  = (bus.fsm_state == STATE_W'(FSM_ST_BUSY));
  assign w_own_done = bus.req_done[r_owner];
  assign w_next_ptr = (r_owner == IDX_W'(NUM_REQ - 1)) ? '0 : r_owner + IDX_W'(1);
  assign w_release  = ((r_state == ST_DRAIN) && w_st_idle) || w_tmo;

`ifdef FSM_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  logic             w_in_job;

  assign w_in_job = (r_state == ST_WAIT1) || (r_state == ST_RUN) || (r_state == ST_DRAIN);
  // Fires on the TIMEOUT-th cycle after entering S_WAIT1.
  assign w_tmo    = w_in_job && (r_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state == ST_START) r_cnt <= '0;
      else if (w_in_job)       r_cnt <= r_cnt + CNT_W'(1);
      if (w_tmo) r_err <= 1'b1;
    end
  end

  assign bus.err = r_err;
`else
  assign w_tmo   = 1'b0;
  assign bus.err = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_grant <= '0;
      r_ack   <= '0;
      r_owner <= '0;
      r_busy  <= 1'b0;
      r_start <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_ack <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_pick_vld) begin
            r_grant <= NUM_REQ'(1) << w_pick_idx;
            r_owner <= w_pick_idx;
            r_busy  <= 1'b1;
            r_start <= 1'b1;
            r_state <= ST_START;
          end
        end
        ST_START: begin
          r_start <= 1'b0;
          r_state <= ST_WAIT1;
        end
        ST_WAIT1: begin
          if (w_st_busy) r_state <= ST_RUN;
        end
        ST_RUN: begin
          r_done <= w_own_done;
          if (w_own_done) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          r_done <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
      // Normal completion and watchdog abort hand the fsm back the same way.
      if (w_release) begin
        r_ack   <= r_grant;
        r_grant <= '0;
        r_busy  <= 1'b0;
        r_start <= 1'b0;
        r_done  <= 1'b0;
        r_ptr   <= w_next_ptr;
        r_state <= ST_IDLE;
      end
    end
  end

  assign bus.grant     = r_grant;
  assign bus.ack       = r_ack;
  assign bus.owner     = r_owner;
  assign bus.busy      = r_busy;
  assign bus.fsm_start = r_start;
  assign bus.fsm_done  = r_done;

endmodule

// File: tb/tb_fsm_rr_scheduler.sv
// Bench for fsm_rr_scheduler: behavioural shared fsm, auto-responding
// requesters, and a grant/ack scoreboard checked by an independent monitor.
module tb_fsm_rr_scheduler;

  localparam int NR  = 4;
  localparam int SW  = 8;
  localparam int TMO = 20;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  fsm_rr_scheduler_if #(.NUM_REQ(NR), .STATE_W(SW)) bus ();

  fsm_rr_scheduler #(.NUM_REQ(NR), .STATE_W(SW), .TIMEOUT(TMO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [NR-1:0] exp_grant_q[$];
  logic [NR-1:0] exp_ack_q[$];
  bit tmo_mode = 1'b0;
  bit resp_en  = 1'b0;
  int resp_dly = 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Shared fsm: idle -> busy on start, busy -> idle on done.
  always @(posedge clock) begin
    if (reset)                                      bus.fsm_state <= '0;
    else if (bus.fsm_state == 0 && bus.fsm_start)   bus.fsm_state <= SW'(1);
    else if (bus.fsm_state == 1 && bus.fsm_done)    bus.fsm_state <= '0;
  end

  // Owner answers req_done resp_dly+1 cycles after the fsm goes busy.
  initial begin : responder
    int cnt;
    bit armed;
    cnt   = 0;
    armed = 1'b1;
    forever begin
      @(posedge clock); #1;
      if (resp_en) begin
        bus.req_done = '0;
        if (bus.fsm_state == 0) begin
          armed = 1'b1;
          cnt   = resp_dly;
        end else if (armed && bus.grant != 0) begin
          if (cnt == 0) begin
            bus.req_done = bus.grant;
            armed = 1'b0;
          end else cnt--;
        end
      end
    end
  end

  initial begin : monitor
    logic [NR-1:0] prev_grant, last_grant;
    int starts, dones;
    prev_grant = '0;
    last_grant = '0;
    starts = 0;
    dones  = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        starts = 0;
        dones  = 0;
      end else begin
        if (bus.grant != 0 && prev_grant == 0) begin
          chk("grant_onehot", int'($onehot(bus.grant)), 1);
          if (exp_grant_q.size() == 0) chk("grant_unexpected", int'(bus.grant), 0);
          else chk("grant_order", int'(bus.grant), int'(exp_grant_q.pop_front()));
          last_grant = bus.grant;
          starts = 0;
          dones  = 0;
        end
        if (bus.fsm_start) starts++;
        if (bus.fsm_done)  dones++;
        if (bus.ack != 0) begin
          if (exp_ack_q.size() == 0) chk("ack_unexpected", int'(bus.ack), 0);
          else chk("ack_bit", int'(bus.ack), int'(exp_ack_q.pop_front()));
          chk("ack_matches_grant", int'(bus.ack), int'(last_grant));
          chk("ack_grant_released", int'(bus.grant), 0);
          if (!tmo_mode) begin
            chk("starts_per_job", starts, 1);
            chk("dones_per_job", dones, 1);
          end
        end
      end
      prev_grant = bus.grant;
    end
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic do_reset(input int n);
    tick();
    reset = 1'b1;
    bus.req = '0;
    if (!resp_en) bus.req_done = '0;
    repeat (n) tick();
    reset = 1'b0;
  endtask

  task automatic wait_grant(input string nm, input int maxc);
    int n;
    n = 0;
    while (bus.grant == 0 && n < maxc) begin
      @(negedge clock);
      n++;
    end
    chk(nm, int'(bus.grant != 0), 1);
  endtask

  task automatic wait_ack(input string nm, input int maxc, output int cyc);
    cyc = 0;
    do begin
      @(negedge clock);
      cyc++;
    end while (bus.ack == 0 && cyc < maxc);
    chk(nm, int'(bus.ack != 0), 1);
  endtask

  task automatic wait_busy_state(input string nm, input int maxc);
    int n;
    n = 0;
    while (bus.fsm_state != 1 && n < maxc) begin
      @(negedge clock);
      n++;
    end
    chk(nm, int'(bus.fsm_state), 1);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "bench watchdog expired");
  end

  initial begin : stim
    int cyc, bad, acks;
    bus.req      = '0;
    bus.req_done = '0;

    // Reset and idle: nothing may move.
    bad = 0;
    repeat (16) begin
      @(negedge clock);
      if (bus.grant != 0 || bus.busy || bus.fsm_start || bus.fsm_state != 0) bad++;
    end
    tick();
    reset = 1'b0;
    repeat (4) begin
      @(negedge clock);
      if (bus.grant != 0 || bus.busy || bus.fsm_start || bus.fsm_state != 0) bad++;
    end
    chk("reset_idle_quiet", bad, 0);
    chk("rst_grant", int'(bus.grant), 0);
    chk("rst_ack", int'(bus.ack), 0);
    chk("rst_owner", int'(bus.owner), 0);
    chk("rst_fsm_done", int'(bus.fsm_done), 0);
    chk("rst_err", int'(bus.err), 0);

    // Single requester; req dropped right after grant.
    resp_en  = 1'b1;
    resp_dly = 1;
    tick();
    bus.req = 4'b0001;
    exp_grant_q.push_back(4'b0001);
    exp_ack_q.push_back(4'b0001);
    @(posedge clock);
    @(negedge clock);
    chk("t2_grant_lat", int'(bus.grant), 1);
    chk("t2_fsm_start", int'(bus.fsm_start), 1);
    chk("t2_owner", int'(bus.owner), 0);
    chk("t2_busy", int'(bus.busy), 1);
    bus.req = '0;
    @(negedge clock);
    chk("t2_start_pulse_width", int'(bus.fsm_start), 0);
    wait_ack("t2_ack", 20, cyc);
    chk("t2_job_len", cyc + 1, 5);
    chk("t2_busy_at_ack", int'(bus.busy), 0);
    chk("t2_fsm_idle_at_ack", int'(bus.fsm_state), 0);

    // All four requesting: strict rotation 0,1,2,3,0.
    do_reset(2);
    tick();
    bus.req = 4'b1111;
    foreach (exp_grant_q[i]) ;
    exp_grant_q.push_back(4'b0001); exp_ack_q.push_back(4'b0001);
    exp_grant_q.push_back(4'b0010); exp_ack_q.push_back(4'b0010);
    exp_grant_q.push_back(4'b0100); exp_ack_q.push_back(4'b0100);
    exp_grant_q.push_back(4'b1000); exp_ack_q.push_back(4'b1000);
    exp_grant_q.push_back(4'b0001); exp_ack_q.push_back(4'b0001);
    acks = 0;
    cyc  = 0;
    while (acks < 5 && cyc < 200) begin
      @(negedge clock);
      cyc++;
      if (bus.ack != 0) begin
        acks++;
        if (acks == 5) bus.req = '0;
      end
    end
    chk("t3_five_acks", acks, 5);
    repeat (3) @(negedge clock);
    chk("t3_idle_after", int'(bus.busy), 0);

    // Non-owner req_done must not reach the fsm.
    resp_en = 1'b0;
    do_reset(2);
    tick();
    bus.req = 4'b0010;
    exp_grant_q.push_back(4'b0010);
    exp_ack_q.push_back(4'b0010);
    wait_grant("t4_grant", 10);
    bus.req = '0;
    chk("t4_owner", int'(bus.owner), 1);
    wait_busy_state("t4_fsm_busy", 10);
    repeat (4) begin
      tick();
      bus.req_done = 4'b0100;
      @(negedge clock);
      chk("t4_nonowner_done", int'(bus.fsm_done), 0);
      chk("t4_state_held", int'(bus.fsm_state), 1);
    end
    tick();
    bus.req_done = 4'b0010;
    tick();
    bus.req_done = '0;
    wait_ack("t4_ack", 20, cyc);

    // Reset mid-run clears everything, including the rr pointer.
    resp_en = 1'b1;
    do_reset(2);
    tick();
    bus.req = 4'b0100;
    exp_grant_q.push_back(4'b0100);
    exp_ack_q.push_back(4'b0100);
    wait_grant("t5a_grant", 10);
    bus.req = '0;
    wait_ack("t5a_ack", 20, cyc);
    resp_en = 1'b0;
    tick();
    bus.req = 4'b1000;
    exp_grant_q.push_back(4'b1000);
    wait_grant("t5b_grant", 10);
    bus.req = '0;
    wait_busy_state("t5b_fsm_busy", 10);
    tick();
    tick();
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("t5_rst_grant", int'(bus.grant), 0);
    chk("t5_rst_busy", int'(bus.busy), 0);
    chk("t5_rst_ack", int'(bus.ack), 0);
    chk("t5_rst_owner", int'(bus.owner), 0);
    chk("t5_rst_start", int'(bus.fsm_start), 0);
    chk("t5_rst_done", int'(bus.fsm_done), 0);
    chk("t5_rst_fsm_state", int'(bus.fsm_state), 0);
    tick();
    reset   = 1'b0;
    bus.req = 4'b1100;
    resp_en = 1'b1;
    exp_grant_q.push_back(4'b0100);
    exp_ack_q.push_back(4'b0100);
    wait_grant("t5c_grant", 10);
    chk("t5_ptr_reset_grant", int'(bus.grant), 4);
    bus.req = '0;
    wait_ack("t5c_ack", 20, cyc);

`ifdef FSM_SCHED_TIMEOUT_EN
    // Owner never finishes: watchdog aborts and latches err.
    resp_en = 1'b0;
    do_reset(2);
    tmo_mode = 1'b1;
    tick();
    bus.req = 4'b0001;
    exp_grant_q.push_back(4'b0001);
    exp_ack_q.push_back(4'b0001);
    wait_grant("t6_grant", 10);
    bus.req = '0;
    wait_ack("t6_tmo_ack", 60, cyc);
    chk("t6_tmo_latency", cyc, TMO + 1);
    chk("t6_err_set", int'(bus.err), 1);
    repeat (10) @(negedge clock);
    chk("t6_err_sticky", int'(bus.err), 1);
    chk("t6_busy_released", int'(bus.busy), 0);
    do_reset(2);
    @(negedge clock);
    chk("t6_err_cleared", int'(bus.err), 0);
    tmo_mode = 1'b0;
`else
    chk("err_tied_low", int'(bus.err), 0);
`endif

    repeat (5) @(negedge clock);
    chk("grant_q_drained", exp_grant_q.size(), 0);
    chk("ack_q_drained", exp_ack_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
